// File: rtl/tensor_seq_pkg.sv
// rtl/tensor_seq_pkg.sv - shared state type and slot-index helpers for the HMMA sequencer
// Contents:
//   seq_state_e  : sequencer FSM states (IDLE / ISSUE / DRAIN)
//   idx_w        : index width of a field with n entries (never below 1 bit)
//   slot_count   : number of issue slots per request
//   slot_octet   : slot index -> octet (step is the fastest-varying field)
//   slot_step    : slot index -> step
`ifndef LATENCY_HMMA
`define LATENCY_HMMA 4
`endif

package tensor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slot_count(input int num_octets, input int num_steps);
    return num_octets * num_steps;
  endfunction

  function automatic int slot_octet(input int cnt, input int num_steps);
    return cnt / num_steps;
  endfunction

  function automatic int slot_step(input int cnt, input int num_steps);
    return cnt % num_steps;
  endfunction

endpackage

// File: rtl/tensor_hmma_seq_if.sv
// rtl/tensor_hmma_seq_if.sv - request, DPU and writeback signals of the HMMA sequencer
// Ports (slave = sequencer side, master = environment side):
//   req_valid/req_ready/req_tag             : HMMA request handshake
//   dpu_valid_in/dpu_octet/dpu_step          : issue slot towards the DPU
//   dpu_stall/dpu_valid_out                  : DPU freeze and result valid
//   wb_valid/wb_ready/wb_octet/wb_step/
//   wb_tag/wb_last                           : D-tile writeback handshake
//   busy                                     : sequencer not idle
interface tensor_hmma_seq_if #(
  parameter int OCTW = 2,
  parameter int STPW = 1,
  parameter int TAGW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [TAGW-1:0] req_tag;
  logic            dpu_valid_in;
  logic [OCTW-1:0] dpu_octet;
  logic [STPW-1:0] dpu_step;
  logic            dpu_stall;
  logic            dpu_valid_out;
  logic            wb_valid;
  logic            wb_ready;
  logic [OCTW-1:0] wb_octet;
  logic [STPW-1:0] wb_step;
  logic [TAGW-1:0] wb_tag;
  logic            wb_last;
  logic            busy;

  modport slave (
    input  req_valid, req_tag, dpu_valid_out, wb_ready,
    output req_ready, dpu_valid_in, dpu_octet, dpu_step, dpu_stall,
           wb_valid, wb_octet, wb_step, wb_tag, wb_last, busy
  );

  modport master (
    output req_valid, req_tag, dpu_valid_out, wb_ready,
    input  req_ready, dpu_valid_in, dpu_octet, dpu_step, dpu_stall,
           wb_valid, wb_octet, wb_step, wb_tag, wb_last, busy
  );
endinterface

// File: rtl/tensor_slot_counter.sv
// rtl/tensor_slot_counter.sv - clear/enable slot counter with terminal-count flag
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear (new request accepted)
//   en         : count one slot
//   cnt        : current slot count, saturates at SLOTS
//   tc         : cnt is the last slot index (SLOTS-1)
module tensor_slot_counter #(
  parameter int SLOTS = 8,
  parameter int CNTW  = $clog2(SLOTS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] cnt,
  output logic            tc
);

  // Saturating at SLOTS keeps the count meaningful after the last slot;
  // only clr brings it back to zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNTW'(SLOTS))) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign tc = (cnt == CNTW'(SLOTS - 1));

endmodule

// File: rtl/tensor_hmma_seq.sv
// rtl/tensor_hmma_seq.sv - HMMA request to DPU issue-slot sequencer with in-order writeback
// Ports:
//   clk, reset : clock, synchronous active-high reset (shared with the DPU)
//   bus        : tensor_hmma_seq_if.slave - request, DPU issue/stall, writeback, busy
// One accepted request issues NUM_OCTETS*NUM_STEPS slots, one per unstalled
// cycle, and returns one tagged D-tile per DPU result in issue order.
`ifndef LATENCY_HMMA
`define LATENCY_HMMA 4
`endif

module tensor_hmma_seq
  import tensor_seq_pkg::*;
#(
  parameter int NUM_OCTETS = 4,
  parameter int NUM_STEPS  = 2,
  parameter int LATENCY    = `LATENCY_HMMA,
  parameter int TAGW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  tensor_hmma_seq_if.slave bus
);

  localparam int OCTW  = idx_w(NUM_OCTETS);
  localparam int STPW  = idx_w(NUM_STEPS);
  localparam int SLOTS = slot_count(NUM_OCTETS, NUM_STEPS);
  localparam int CNTW  = $clog2(SLOTS + 1);

  seq_state_e      state;
  logic            issue_en;
  logic            ready_q;
  logic            busy_q;
  logic [TAGW-1:0] tag_q;

  logic [CNTW-1:0] issue_cnt;
  logic [CNTW-1:0] wb_cnt;
  logic            issue_tc;
  logic            wb_tc;

  logic            accept;
  logic            stall;
  logic            issue_fire;
  logic            wb_fire;

  assign accept     = bus.req_valid & ready_q;
  // A result the writeback side cannot take freezes the whole DPU pipe,
  // so nothing new may enter it either.
  assign stall      = bus.dpu_valid_out & ~bus.wb_ready;
  assign issue_fire = issue_en & ~stall;
  assign wb_fire    = bus.dpu_valid_out & bus.wb_ready;

  tensor_slot_counter #(.SLOTS(SLOTS), .CNTW(CNTW)) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (issue_fire),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  tensor_slot_counter #(.SLOTS(SLOTS), .CNTW(CNTW)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (wb_fire),
    .cnt   (wb_cnt),
    .tc    (wb_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      issue_en <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tag_q    <= bus.req_tag;
            state    <= ISSUE;
            issue_en <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_fire && issue_tc) begin
            state    <= DRAIN;
            issue_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (wb_fire && wb_tc) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          issue_en <= 1'b0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.dpu_stall    = stall;
  assign bus.dpu_valid_in = issue_fire;
  assign bus.dpu_octet    = OCTW'(slot_octet(int'(issue_cnt), NUM_STEPS));
  assign bus.dpu_step     = STPW'(slot_step(int'(issue_cnt), NUM_STEPS));
  assign bus.wb_valid     = bus.dpu_valid_out;
  assign bus.wb_octet     = OCTW'(slot_octet(int'(wb_cnt), NUM_STEPS));
  assign bus.wb_step      = STPW'(slot_step(int'(wb_cnt), NUM_STEPS));
  assign bus.wb_tag       = tag_q;
  assign bus.wb_last      = wb_tc;

  // A result with nothing outstanding means the DPU broke the protocol.
  a_no_orphan_result: assert property (@(posedge clk) disable iff (reset)
    bus.dpu_valid_out |-> (wb_cnt != issue_cnt));
  a_wb_behind_issue: assert property (@(posedge clk) disable iff (reset)
    wb_cnt <= issue_cnt);
  // The pipe cannot hold more slots than it has stages.
  a_in_flight_depth: assert property (@(posedge clk) disable iff (reset)
    (int'(issue_cnt) - int'(wb_cnt)) <= LATENCY);

endmodule

// File: tb/tb_tensor_hmma_seq.sv
// tb/tb_tensor_hmma_seq.sv - scoreboard bench for tensor_hmma_seq (4x2 lat 4, plus 1x1 lat 1)
module tb_tensor_hmma_seq;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tensor_hmma_seq_if #(.OCTW(2), .STPW(1), .TAGW(8)) bus0 ();
  tensor_hmma_seq_if #(.OCTW(1), .STPW(1), .TAGW(8)) bus1 ();

  tensor_hmma_seq #(.NUM_OCTETS(4), .NUM_STEPS(2), .LATENCY(LAT), .TAGW(8)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  tensor_hmma_seq #(.NUM_OCTETS(1), .NUM_STEPS(1), .LATENCY(1), .TAGW(8)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // Fixed-latency DPU models that freeze on stall and share the reset.
  logic [LAT-1:0] pipe0;
  logic           pipe1;
  always @(posedge clk) begin
    if (reset) pipe0 <= '0;
    else if (!bus0.dpu_stall) pipe0 <= {pipe0[LAT-2:0], bus0.dpu_valid_in};
  end
  always @(posedge clk) begin
    if (reset) pipe1 <= 1'b0;
    else if (!bus1.dpu_stall) pipe1 <= bus1.dpu_valid_in;
  end
  assign bus0.dpu_valid_out = pipe0[LAT-1];
  assign bus1.dpu_valid_out = pipe1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] tag;
    int         oct;
    int         stp;
    int         last;
  } tile_t;

  tile_t sbq[$];
  int    iq[$];

  // Per-request event record, rebased at every accept.
  int acc_cyc = 0, first_iss = -1, last_iss = -1, first_wb = -1, last_wb = -1;
  int first_stall = -1, last_stall = -1, done_cyc = -1;
  int n_iss = 0, n_wb = 0, n_stall = 0, tot_wb = 0, n_lastflag = 0;
  bit in_req = 0;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      iq.delete();
      in_req = 0;
    end else begin
      chk("wb_valid_follows_dpu", int'(bus0.wb_valid), int'(bus0.dpu_valid_out));
      chk("stall_rule", int'(bus0.dpu_stall), int'(bus0.dpu_valid_out & ~bus0.wb_ready));
      if (bus0.req_valid && bus0.req_ready) begin
        acc_cyc = cyc; first_iss = -1; last_iss = -1; first_wb = -1; last_wb = -1;
        first_stall = -1; last_stall = -1; done_cyc = -1;
        n_iss = 0; n_wb = 0; n_stall = 0; n_lastflag = 0; in_req = 1;
        for (int k = 0; k < 8; k++) begin
          iq.push_back(k);
          sbq.push_back('{tag: bus0.req_tag, oct: k / 2, stp: k % 2, last: int'(k == 7)});
        end
      end else if (in_req && bus0.req_ready) begin
        done_cyc = cyc;
        in_req = 0;
      end
      if (bus0.dpu_valid_in) begin
        if (n_iss == 0) first_iss = cyc;
        last_iss = cyc;
        n_iss++;
        chk("issue_expected", int'(iq.size() != 0), 1);
        if (iq.size() != 0) begin
          int k;
          k = iq.pop_front();
          chk("issue_octet", int'(bus0.dpu_octet), k / 2);
          chk("issue_step", int'(bus0.dpu_step), k % 2);
        end
      end
      if (bus0.dpu_stall) begin
        if (n_stall == 0) first_stall = cyc;
        last_stall = cyc;
        n_stall++;
      end
      if (bus0.wb_valid && bus0.wb_last) n_lastflag++;
      if (bus0.wb_valid && bus0.wb_ready) begin
        if (n_wb == 0) first_wb = cyc;
        last_wb = cyc;
        n_wb++;
        tot_wb++;
        chk("wb_expected", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          tile_t e;
          e = sbq.pop_front();
          chk("wb_octet", int'(bus0.wb_octet), e.oct);
          chk("wb_step", int'(bus0.wb_step), e.stp);
          chk("wb_tag", int'(bus0.wb_tag), int'(e.tag));
          chk("wb_last", int'(bus0.wb_last), e.last);
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] tag);
    bit acc;
    acc = 0;
    bus0.req_valid = 1'b1;
    bus0.req_tag   = tag;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = bus0.req_ready;
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    chk("req_accepted", int'(acc), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && (in_req || done_cyc < 0); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, int'(!in_req && done_cyc >= 0), 1);
  endtask

  bit rnd_on = 0;

  initial begin
    int a1, wb0;
    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_tag = '0; bus0.wb_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_tag = '0; bus1.wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", int'(bus0.req_ready), 1);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_dpu_valid_in", int'(bus0.dpu_valid_in), 0);
    chk("rst_wb_valid", int'(bus0.wb_valid), 0);
    chk("rst_stall", int'(bus0.dpu_stall), 0);
    @(posedge clk); #1;

    // 1x1 configuration, latency 1
    bus1.req_valid = 1'b1; bus1.req_tag = 8'hC3;
    @(negedge clk);
    chk("c1_accept", int'(bus1.req_ready), 1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("c1_issue", int'(bus1.dpu_valid_in), 1);
    chk("c1_issue_idx", int'({bus1.dpu_octet, bus1.dpu_step}), 0);
    chk("c1_wb_early", int'(bus1.wb_valid), 0);
    @(negedge clk);
    chk("c1_wb_valid", int'(bus1.wb_valid), 1);
    chk("c1_wb_last", int'(bus1.wb_last), 1);
    chk("c1_wb_tag", int'(bus1.wb_tag), 'hC3);
    chk("c1_no_reissue", int'(bus1.dpu_valid_in), 0);
    chk("c1_ready_low", int'(bus1.req_ready), 0);
    @(negedge clk);
    chk("c1_idle_ready", int'(bus1.req_ready), 1);
    chk("c1_idle_busy", int'(bus1.busy), 0);
    @(posedge clk); #1;

    // Single request, writeback always ready
    send_req(8'h5A);
    wait_done("t1_done");
    chk("t1_first_issue", first_iss - acc_cyc, 1);
    chk("t1_last_issue", last_iss - acc_cyc, 8);
    chk("t1_issue_count", n_iss, 8);
    chk("t1_first_wb", first_wb - acc_cyc, 5);
    chk("t1_last_wb", last_wb - acc_cyc, 12);
    chk("t1_last_flag_count", n_lastflag, 1);
    chk("t1_ready_again", done_cyc - acc_cyc, 13);

    // Backpressure in cycles 6..8
    send_req(8'hB2);
    repeat (5) begin @(posedge clk); #1; end
    bus0.wb_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus0.wb_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_stall_count", n_stall, 3);
    chk("t2_first_stall", first_stall - acc_cyc, 6);
    chk("t2_last_stall", last_stall - acc_cyc, 8);
    chk("t2_issue_count", n_iss, 8);
    chk("t2_last_issue", last_iss - acc_cyc, 11);
    chk("t2_wb_count", n_wb, 8);
    chk("t2_last_wb", last_wb - acc_cyc, 15);

    // Request held while busy
    send_req(8'h22);
    a1 = acc_cyc;
    send_req(8'h11);
    chk("t3_second_accept", acc_cyc - a1, 13);
    wait_done("t3_done");
    chk("t3_first_wb", first_wb - acc_cyc, 1 + LAT);
    chk("t3_wb_count", n_wb, 8);

    // Reset in the middle of a request
    send_req(8'h33);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_req_ready", int'(bus0.req_ready), 1);
    chk("t4_wb_valid", int'(bus0.wb_valid), 0);
    chk("t4_busy", int'(bus0.busy), 0);
    chk("t4_dpu_valid_in", int'(bus0.dpu_valid_in), 0);
    @(posedge clk); #1;
    send_req(8'h44);
    wait_done("t4_done");
    chk("t4_wb_count", n_wb, 8);
    chk("t4_issue_count", n_iss, 8);

    // 200 back-to-back requests with random writeback backpressure
    wb0 = tot_wb;
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          bus0.wb_ready = ($urandom_range(0, 1) == 1);
        end
        bus0.wb_ready = 1'b1;
      end
    join_none
    for (int r = 0; r < 200; r++) send_req(8'($urandom_range(0, 255)));
    wait_done("t6_done");
    rnd_on = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_total_tiles", tot_wb - wb0, 1600);
    chk("t6_sb_empty", sbq.size(), 0);
    chk("t6_iq_empty", iq.size(), 0);
    chk("t6_idle", int'(bus0.req_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tensor_hmma_seq.md
Name: tensor_hmma_seq

Overview:
Sequencer for the tensor dot-product unit (DPU) datapath. It accepts one HMMA request per warp instruction and expands it into NUM_OCTETS × NUM_STEPS DPU issue slots, one slot per cycle. It tracks results through the fixed-latency DPU pipeline and drives the DPU stall. It returns each D-tile to writeback in issue order, tagged with octet, step and request tag, and marks the last tile.

Parameters:
NUM_OCTETS, 4, octets per HMMA instruction (power of 2)
NUM_STEPS, 2, inner-step (ISW) slots per octet (power of 2)
LATENCY, `LATENCY_HMMA, DPU pipeline depth in cycles (≥1)
TAGW, 8, request tag width
Local constants: OCTW=$clog2(NUM_OCTETS), STPW=$clog2(NUM_STEPS), SLOTS=NUM_OCTETS*NUM_STEPS, CNTW=$clog2(SLOTS+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  HMMA request valid
req_ready  out  1  sequencer can accept a request
req_tag  in  TAGW  request identifier (warp/uuid)
dpu_valid_in  out  1  issue slot valid to DPU
dpu_octet  out  OCTW  octet index of the issued slot (operand select)
dpu_step  out  STPW  step index of the issued slot (operand select)
dpu_stall  out  1  freeze the DPU pipeline
dpu_valid_out  in  1  DPU result valid
wb_valid  out  1  result tile available
wb_ready  in  1  writeback accepts tile
wb_octet  out  OCTW  octet of the returned tile
wb_step  out  STPW  step of the returned tile
wb_tag  out  TAGW  tag of the owning request
wb_last  out  1  final tile of the request
busy  out  1  state != IDLE

Behaviour:
- FSM states are IDLE, ISSUE and DRAIN. Reset forces IDLE and clears issue_cnt, wb_cnt and the tag register.
- Output reset values: req_ready=1, busy=0, dpu_valid_in=0, wb_valid=0, dpu_stall=0.
- req_ready = (state==IDLE). On req_valid&req_ready: latch req_tag, clear both counters, go to ISSUE.
- ISSUE:
  - dpu_valid_in = ~dpu_stall.
  - The slot index is issue_cnt: dpu_octet = issue_cnt / NUM_STEPS, dpu_step = issue_cnt % NUM_STEPS (step is the fastest-varying field).
  - Each unstalled cycle increments issue_cnt.
  - After the issue of slot SLOTS-1, go to DRAIN.
  - Minimum issue time is SLOTS cycles.
- dpu_stall = dpu_valid_out & ~wb_ready, combinational. While it is high, the DPU pipeline holds and no slot issues (issue_cnt holds).
- wb_valid = dpu_valid_out. wb_octet and wb_step are decoded from wb_cnt. wb_tag is the latched tag. wb_last = (wb_cnt==SLOTS-1).
- A wb_valid&wb_ready handshake increments wb_cnt.
- DRAIN: dpu_valid_in=0. The cycle that completes the wb_last handshake moves the FSM to IDLE; req_ready goes high the following cycle.
- Timing: a slot issued in cycle t with no stall presents wb_valid in cycle t+LATENCY. Each stall cycle adds one cycle to that arrival.
- Ordering: results return strictly in issue order. wb_cnt never exceeds issue_cnt. A dpu_valid_out while wb_cnt==issue_cnt is a protocol error; flag it with an assertion.
- Simultaneous events: issue and writeback in the same cycle is legal. The two counters update independently.
- wb_ready low for many cycles: the pipeline freezes, and no results or issues are lost or duplicated.
- Reset mid-operation: the FSM returns to IDLE. The DPU shares the same reset, so in-flight results are discarded; there is no partial writeback afterwards.
- req_valid while busy is held off by req_ready=0, with no side effect.
- Counters wrap only via clear-on-accept. They never roll past SLOTS.

Decomposition:
- Package tensor_seq_pkg:
  - state enum (IDLE/ISSUE/DRAIN)
  - slot-index decode function (cnt → {octet, step})
  - SLOTS/OCTW/STPW derivation
- Single sub-module: tensor_slot_counter. It is a clear/enable counter with a terminal-count flag and is instantiated twice (issue_cnt, wb_cnt).
- FSM and stall logic stay in the top module.

Test Plan (NUM_OCTETS=4, NUM_STEPS=2, LATENCY=4 unless stated):
- Single request: tag=0x5A accepted at cycle 0, wb_ready=1 → dpu_valid_in high in cycles 1–8 with (octet,step) = (0,0),(0,1),(1,0)…(3,1). wb_valid in cycles 5–12 with matching indices and tag 0x5A. wb_last only in cycle 12. req_ready high again in cycle 13.
- Backpressure: wb_ready=0 in cycles 6–8 → dpu_stall high in exactly those cycles and issue pauses. Every slot is returned exactly once, in order, and the last tile is delayed by 3 cycles.
- Request while busy: req_valid held through cycles 1–12 with tag 0x11 → not accepted until req_ready rises. The second request's tiles carry tag 0x11 and start 1+LATENCY cycles after its accept.
- Reset at cycle 6: assert reset for 1 cycle → the next cycle shows req_ready=1, wb_valid=0, busy=0. A following request completes normally with 8 tiles.
- Corner config NUM_OCTETS=1, NUM_STEPS=1, LATENCY=1: request accepted at cycle 0 → one issue at cycle 1, wb_valid=wb_last at cycle 2, IDLE at cycle 3.
- Random wb_ready (50% probability) over 200 back-to-back requests → a scoreboard shows no loss, duplicates or reordering, and the counter assertions never fire.
